// File: rtl/fft_peak_reader.sv
// ---------------------------------------------------------------------------
// fft_peak_reader
//
// Scans the positive-frequency half of a 512-point FFT result RAM and reports
// the bin with the largest power (re^2 + im^2).  One scan is launched by a
// single-cycle start pulse.  The module walks read_address from FIRST_BIN to
// LAST_BIN, one address per clock.  It squares and sums each returned sample
// in a short pipeline and keeps a running maximum.  When the last sample has
// been compared it pulses done and publishes the winner on peak_bin/peak_mag.
//
// Parameters
//   FIRST_BIN    first bin read (default 1, so DC is skipped)
//   LAST_BIN     last bin read  (default 255, top of the positive half)
//
// Ports
//   clk          single clock, all state on its rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle scan request, honoured only while idle
//   read_address read address of the 512x32 result RAM
//   q            RAM data {re[31:16], im[15:0]}, signed, one cycle after address
//   busy         high while a scan is in progress (SWEEP, DRAIN, DONE)
//   done         one-cycle pulse, coincident with the peak_* update
//   peak_bin     bin index of the largest magnitude from the last full scan
//   peak_mag     re^2+im^2 of that bin, unsigned 33 bits
//
// Timing
//   With N = LAST_BIN-FIRST_BIN+1 and start sampled at edge 0, the address of
//   scan bin k is presented at edge k.  The RAM returns it at edge k+1, the
//   squares are registered at edge k+2 and the compare happens at edge k+3.
//   The last bin is therefore compared at edge N+2.  The FSM enters DONE at
//   edge N+3, so done is high in the cycle after edge N+3.
// ---------------------------------------------------------------------------
module fft_peak_reader #(
    parameter int FIRST_BIN = 1,
    parameter int LAST_BIN  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [8:0]  read_address,
    input  logic [31:0] q,
    output logic        busy,
    output logic        done,
    output logic [8:0]  peak_bin,
    output logic [32:0] peak_mag
);

    localparam logic [8:0] FIRST_ADDR = 9'(FIRST_BIN);
    localparam logic [8:0] LAST_ADDR  = 9'(LAST_BIN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [8:0]  addr_next;
    logic        scan_start;
    logic        scan_finish;

    // Pipeline bookkeeping: a valid flag and the bin index travel alongside
    // the data, so the compare stage knows which bin it is looking at.
    logic        addr_valid;
    logic        q_valid;
    logic [8:0]  q_bin;
    logic        prod_valid;
    logic [8:0]  prod_bin;
    logic [31:0] prod_re;
    logic [31:0] prod_im;

    // Sign-extended operands and their squares
    logic signed [31:0] re_ext;
    logic signed [31:0] im_ext;
    logic signed [31:0] sq_re;
    logic signed [31:0] sq_im;
    logic [32:0]        mag_sum;

    // Running maximum of the scan in progress
    logic [32:0] run_mag;
    logic [8:0]  run_bin;

    // The squares are formed at full 32-bit width.  The largest square
    // ((-32768)^2 = 2^30) is still positive in 32 bits, so reading the
    // result as unsigned is safe.  The 33-bit sum holds the worst case 2^31
    // without overflow.
    assign re_ext  = {{16{q[31]}}, q[31:16]};
    assign im_ext  = {{16{q[15]}}, q[15:0]};
    assign sq_re   = re_ext * re_ext;
    assign sq_im   = im_ext * im_ext;
    assign mag_sum = {1'b0, prod_re} + {1'b0, prod_im};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, address sequencing and status outputs.
    // DRAIN waits until both later pipeline stages are empty.  At that point
    // the last bin has already been folded into the running maximum.
    always_comb begin
        state_next  = state;
        addr_next   = read_address;
        busy        = 1'b0;
        done        = 1'b0;
        scan_start  = 1'b0;
        scan_finish = 1'b0;

        case (state)
            IDLE: begin
                addr_next = FIRST_ADDR;
                if (start) begin
                    state_next = SWEEP;
                    scan_start = 1'b1;
                end
            end

            SWEEP: begin
                busy = 1'b1;
                if (read_address == LAST_ADDR) begin
                    state_next = DRAIN;
                end else begin
                    addr_next = read_address + 9'd1;
                end
            end

            DRAIN: begin
                busy = 1'b1;
                if (!q_valid && !prod_valid) begin
                    state_next  = DONE;
                    scan_finish = 1'b1;
                end
            end

            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                addr_next  = FIRST_ADDR;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                addr_next  = FIRST_ADDR;
            end
        endcase
    end

    // Read address register.  It is marked valid exactly while the FSM
    // stays in (or enters) SWEEP, so one valid token is issued per bin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_address <= FIRST_ADDR;
            addr_valid   <= 1'b0;
        end else begin
            read_address <= addr_next;
            addr_valid   <= (state_next == SWEEP);
        end
    end

    // Data pipeline.  The first stage mirrors the RAM's one-cycle read
    // latency: the address presented on the previous edge is what q now
    // holds.  The second stage registers the two squares.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_valid    <= 1'b0;
            q_bin      <= '0;
            prod_valid <= 1'b0;
            prod_bin   <= '0;
            prod_re    <= '0;
            prod_im    <= '0;
        end else begin
            q_valid    <= addr_valid;
            q_bin      <= read_address;
            prod_valid <= q_valid;
            prod_bin   <= q_bin;
            prod_re    <= unsigned'(sq_re);
            prod_im    <= unsigned'(sq_im);
        end
    end

    // Running maximum.  A strict greater-than keeps the earliest (lowest)
    // bin on ties, and an all-zero spectrum leaves the FIRST_BIN default.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_mag <= '0;
            run_bin <= FIRST_ADDR;
        end else if (scan_start) begin
            run_mag <= '0;
            run_bin <= FIRST_ADDR;
        end else if (prod_valid && (mag_sum > run_mag)) begin
            run_mag <= mag_sum;
            run_bin <= prod_bin;
        end
    end

    // Published result.  It is loaded on the edge that enters DONE, so the
    // new values appear together with the done pulse.  It holds through any
    // later scan until that scan completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_bin <= '0;
            peak_mag <= '0;
        end else if (scan_finish) begin
            peak_bin <= run_bin;
            peak_mag <= run_mag;
        end
    end

endmodule

// File: doc/fft_peak_reader.md
FFT_PEAK_READER -- requirements
Module: fft_peak_reader

Interface
REQ-001 SHALL have parameter FIRST_BIN, default 1: first bin read; skips DC.
REQ-002 SHALL have parameter LAST_BIN, default 255: last bin read; covers the positive half of the 512-point spectrum.
REQ-003 SHALL have port clk  input  1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1: one-cycle request to scan the result RAM.
REQ-006 SHALL have port read_address  output  9: drives the read address of the 512x32 result RAM.
REQ-007 SHALL have port q  input  32: RAM read data, {re[31:16], im[15:0]}, both signed two's complement; valid one cycle after its address.
REQ-008 SHALL have port busy  output  1: high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1: one-cycle pulse when peak_bin and peak_mag update.
REQ-010 SHALL have port peak_bin  output  9: index of the largest-magnitude bin from the last completed scan.
REQ-011 SHALL have port peak_mag  output  33: re^2+im^2 of that bin, unsigned.

Function
REQ-012 SHALL implement states IDLE, SWEEP, DRAIN, DONE.
REQ-013 IDLE: start=1 SHALL go to SWEEP, load read_address=FIRST_BIN, and clear the running max to 0 and the running bin to FIRST_BIN.
REQ-014 SWEEP SHALL increment read_address by 1 per cycle through LAST_BIN, then go to DRAIN holding read_address=LAST_BIN.
REQ-015 Pipeline: edge a presents address; edge a+1 RAM returns q; edge a+2 registers re*re and im*im (signed 16x16, 32-bit); edge a+3 registers the 33-bit sum and the compare/update.
REQ-016 DRAIN SHALL last until the LAST_BIN result has been compared, then go to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, copy the running max/bin to peak_mag/peak_bin, and return to IDLE.
REQ-018 With N=LAST_BIN-FIRST_BIN+1 and start sampled at edge 0, done SHALL be high in the cycle after edge N+3 (258 with defaults).
REQ-019 Update SHALL occur only when the new magnitude is strictly greater than the running max; ties SHALL keep the lowest bin.
REQ-020 All-zero spectrum SHALL report peak_bin=FIRST_BIN, peak_mag=0.
REQ-021 re=im=-32768 SHALL give 2^31: no overflow in 33 bits, no saturation.
REQ-022 start while busy or in DONE SHALL be ignored; no queuing, no restart.
REQ-023 peak_bin and peak_mag SHALL hold between done pulses, including during a new scan.
REQ-024 busy SHALL be high in SWEEP, DRAIN and DONE; low in IDLE.
REQ-025 read_address SHALL equal FIRST_BIN while in IDLE.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, peak_bin=0, peak_mag=0, read_address=FIRST_BIN, and clear the pipeline registers.
REQ-027 Reset mid-scan SHALL abort with no done pulse; the first start after release SHALL run a complete, uncorrupted scan.

Verification
REQ-028 Bench SHALL cover: RAM model with bin 37 = {16'sd300, 16'sd400}, all others 0; start -> done at edge 258, peak_bin=37, peak_mag=250000.
REQ-029 Bench SHALL cover: bins 10 and 200 both {100,0}, all others {1,1} -> peak_bin=10, peak_mag=10000.
REQ-030 Bench SHALL cover: bin 0 = {32767,0} (DC, excluded), bin 255 = {-32768,-32768} -> peak_bin=255, peak_mag=0x080000000.
REQ-031 Bench SHALL cover: second start pulse at cycle 50 of a scan -> ignored; exactly one done, at edge 258 of the first scan.
REQ-032 Bench SHALL cover: reset_n low at cycle 100 of a scan -> outputs 0 within the same cycle, no done; restart -> correct result with done at edge 258 from the new start.
REQ-033 Bench SHALL cover: read_address trace -> FIRST_BIN..LAST_BIN, one per cycle, no gaps or repeats; outputs stable between done pulses.
